// File: rtl/bus_master_port.sv
// bus_master_port: turns controller commands into serial bus transactions with grant-loss retry and timeout
module bus_master_port #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  grant,
  input  logic                  slave_ready,
  input  logic                  bus_in,
  input  logic                  bus_in_valid,
  output logic                  request,
  output logic                  bus_out,
  output logic                  bus_out_valid,
  output logic                  bus_mode,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  error,
  output logic                  busy
);
  localparam int TW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(TW + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, ADDR, WDATA, WAIT_ACK, WAIT_RD, RDATA, DONE} state_t;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [TW-1:0] tx, tx_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] data_q, data_n, sh, sh_n, rdata_n;
  logic rd_q, rd_n, en_q, err_n, tmo, last_rd;
  // next-state and datapath: address and write data share one shift register, reloaded on every (re)grant
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    wcnt_n = wcnt;
    tx_n = tx;
    sh_n = sh;
    addr_n = addr_q;
    data_n = data_q;
    rd_n = rd_q;
    rdata_n = data_out;
    err_n = error;
    tmo = wcnt == WW'(TIMEOUT - 1);
    last_rd = bus_in_valid && cnt == CW'(DATA_WIDTH - 1);
    case (st)
      IDLE: if (enable && !en_q) begin
        st_n = REQ;
        addr_n = addr_in;
        data_n = data_in;
        rd_n = read_en;
        err_n = 1'b0;
      end
      REQ: if (grant) begin
        st_n = ADDR;
        cnt_n = '0;
        tx_n = {addr_q, data_q};
      end
      ADDR, WDATA: if (!grant) begin
        st_n = REQ;
        cnt_n = '0;
      end else begin
        cnt_n = cnt + 1'b1;
        tx_n = tx << 1;
        wcnt_n = '0;
        if (st == ADDR && cnt == CW'(ADDR_WIDTH - 1)) begin
          st_n = rd_q ? WAIT_RD : WDATA;
          if (rd_q) cnt_n = '0;
        end else if (st == WDATA && cnt == CW'(TW - 1)) st_n = WAIT_ACK;
      end
      WAIT_ACK: begin
        wcnt_n = wcnt + 1'b1;
        st_n = (slave_ready || tmo) ? DONE : WAIT_ACK;
        err_n = !slave_ready && tmo;
      end
      WAIT_RD, RDATA: begin
        wcnt_n = wcnt + 1'b1;
        if (bus_in_valid) begin
          sh_n = {sh[DATA_WIDTH-2:0], bus_in};
          cnt_n = cnt + 1'b1;
          st_n = RDATA;
        end
        if (last_rd) begin
          st_n = DONE;
          rdata_n = sh_n;
        end else if (tmo) begin
          st_n = DONE;
          err_n = 1'b1;
        end
      end
      DONE: st_n = IDLE;
    endcase
  end
  // state, shadow registers and outputs registered from the next-state values
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      wcnt <= '0;
      tx <= '0;
      sh <= '0;
      addr_q <= '0;
      data_q <= '0;
      rd_q <= 1'b0;
      en_q <= 1'b0;
      request <= 1'b0;
      bus_out <= 1'b0;
      bus_out_valid <= 1'b0;
      bus_mode <= 1'b0;
      data_out <= '0;
      done <= 1'b0;
      error <= 1'b0;
      busy <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      wcnt <= wcnt_n;
      tx <= tx_n;
      sh <= sh_n;
      addr_q <= addr_n;
      data_q <= data_n;
      rd_q <= rd_n;
      en_q <= enable;
      request <= st_n inside {REQ, ADDR, WDATA, WAIT_ACK, WAIT_RD, RDATA};
      bus_out_valid <= st_n == ADDR || st_n == WDATA;
      bus_out <= (st_n == ADDR || st_n == WDATA) && tx_n[TW-1];
      bus_mode <= st_n == ADDR && rd_n;
      data_out <= rdata_n;
      done <= st_n == DONE;
      error <= err_n;
      busy <= st_n != IDLE;
    end
  end
endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: scoreboard bench for bus_master_port with directed transactions
module tb_bus_master_port;
  logic clk = 0, reset = 1, enable = 0, read_en = 0, grant = 0, slave_ready = 0, bus_in = 0, bus_in_valid = 0;
  logic [7:0] data_in = 0;
  logic [13:0] addr_in = 0;
  logic request, bus_out, bus_out_valid, bus_mode, done, error, busy;
  logic [7:0] data_out;
  int errors = 0, checks = 0, dones = 0, cyc, n, d0;
  logic [1:0] exp_bits[$];
  logic [8:0] exp_done[$];
  logic [1:0] eb;
  logic [8:0] ed;
  logic [8:0] rb = 9'b101000101;
  logic [8:0] rv = 9'b111101111;

  bus_master_port dut (
    .clk(clk), .reset(reset), .enable(enable), .read_en(read_en), .data_in(data_in),
    .addr_in(addr_in), .grant(grant), .slave_ready(slave_ready), .bus_in(bus_in),
    .bus_in_valid(bus_in_valid), .request(request), .bus_out(bus_out),
    .bus_out_valid(bus_out_valid), .bus_mode(bus_mode), .data_out(data_out),
    .done(done), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_bits(input logic [21:0] v, input int cnt, input logic m);
    logic [21:0] s;
    s = v;
    for (int i = 0; i < cnt; i++) begin
      exp_bits.push_back({s[21], m});
      s = s << 1;
    end
  endtask

  task automatic start_txn(input logic [13:0] a, input logic [7:0] d, input logic rd, input logic hold);
    addr_in = a;
    data_in = d;
    read_en = rd;
    @(negedge clk) enable = 1;
    @(negedge clk) enable = hold;
    chk("start_request", 32'(request), 1);
    chk("start_error_clear", 32'(error), 0);
  endtask

  task automatic wait_done(output int c);
    c = 1;
    do begin
      @(negedge clk);
      c++;
      if (!done) chk("request_held", 32'(request), 1);
    end while (!done && c < 300);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_idle();
    @(negedge clk);
    chk("idle_after_done", 32'({done, busy, request, bus_out_valid}), 0);
  endtask

  // monitor: every presented bus bit and every done pulse is checked against the scoreboard
  always @(negedge clk) begin
    if (bus_out_valid) begin
      if (exp_bits.size() == 0) chk("unexpected_bit", 1, 0);
      else begin
        eb = exp_bits.pop_front();
        chk("bus_out", 32'(bus_out), 32'(eb[1]));
        chk("bus_mode", 32'(bus_mode), 32'(eb[0]));
      end
    end else chk("bus_out_idle", 32'(bus_out), 0);
    if (done) begin
      dones++;
      if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        ed = exp_done.pop_front();
        chk("done_error", 32'(error), 32'(ed[8]));
        chk("done_data", 32'(data_out), 32'(ed[7:0]));
        chk("done_request", 32'(request), 0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({request, bus_out, bus_out_valid, bus_mode, done, error, busy, data_out}), 0);
    reset = 0;
    grant = 1;
    slave_ready = 1;
    // write 1001 <- 101, grant tied high
    push_bits({14'd1001, 8'd101}, 22, 0);
    exp_done.push_back({1'b0, 8'h00});
    start_txn(14'd1001, 8'd101, 0, 0);
    wait_done(cyc);
    chk("write_latency", cyc, 25);
    chk_idle();
    // read 5097, slave returns A5 with one gap cycle
    push_bits({14'd5097, 8'd0}, 14, 1);
    exp_done.push_back({1'b0, 8'hA5});
    start_txn(14'd5097, 8'd0, 1, 0);
    repeat (14) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus_in = rb[8-i];
      bus_in_valid = rv[8-i];
    end
    @(negedge clk);
    bus_in_valid = 0;
    bus_in = 0;
    chk("read_done_cycle", 32'(done), 1);
    chk("read_data", 32'(data_out), 32'h A5);
    chk_idle();
    // grant withheld 5 cycles, then lost for 2 cycles after 7 address bits
    grant = 0;
    push_bits({14'h2ABC, 8'h3C}, 7, 0);
    push_bits({14'h2ABC, 8'h3C}, 22, 0);
    exp_done.push_back({1'b0, 8'hA5});
    start_txn(14'h2ABC, 8'h3C, 0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("withheld_request", 32'({request, bus_out_valid}), 2);
    end
    grant = 1;
    n = 0;
    for (int i = 0; i < 50 && n < 7; i++) begin
      @(negedge clk);
      if (bus_out_valid) n++;
    end
    chk("bits_before_loss", n, 7);
    grant = 0;
    repeat (2) begin
      @(negedge clk);
      chk("lost_grant_request", 32'({request, bus_out_valid}), 2);
    end
    grant = 1;
    wait_done(cyc);
    chk_idle();
    // slave never acknowledges: timeout after 16 wait cycles
    slave_ready = 0;
    push_bits({14'h0123, 8'hC3}, 22, 0);
    exp_done.push_back({1'b1, 8'hA5});
    start_txn(14'h0123, 8'hC3, 0, 0);
    wait_done(cyc);
    chk("timeout_latency", cyc, 40);
    chk_idle();
    chk("timeout_data_kept", 32'(data_out), 32'hA5);
    slave_ready = 1;
    // enable held high for 40 cycles gives exactly one transaction
    d0 = dones;
    push_bits({14'h2001, 8'h5A}, 22, 0);
    exp_done.push_back({1'b0, 8'hA5});
    start_txn(14'h2001, 8'h5A, 0, 1);
    wait_done(cyc);
    chk("held_latency", cyc, 25);
    repeat (15) @(negedge clk);
    enable = 0;
    repeat (10) @(negedge clk);
    chk("single_txn", dones - d0, 1);
    // reset mid-WDATA
    push_bits({14'h1555, 8'hF0}, 22, 0);
    exp_done.push_back({1'b0, 8'hA5});
    start_txn(14'h1555, 8'hF0, 0, 0);
    n = 0;
    for (int i = 0; i < 100 && n < 17; i++) begin
      @(negedge clk);
      if (bus_out_valid) n++;
    end
    chk("bits_before_reset", n, 17);
    reset = 1;
    @(negedge clk);
    chk("mid_reset_outputs", 32'({request, bus_out, bus_out_valid, bus_mode, done, error, busy, data_out}), 0);
    reset = 0;
    exp_bits.delete();
    exp_done.delete();
    d0 = dones;
    repeat (30) @(negedge clk);
    chk("no_done_after_reset", dones - d0, 0);
    chk("after_reset_busy", 32'(busy), 0);
    chk("bits_queue_empty", exp_bits.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
